// File: rtl/vscpu_boot_mem.sv
// Word-addressed 32-bit program/data memory for the VSCPU core with a byte-stream
// boot loader that holds the core in reset while loading. Optional MMIO output: VSCPU_MMIO_OUT_EN.
module vscpu_boot_mem #(
  parameter int                ADDR_W     = 14,
  parameter int                DEPTH      = 16384,
  parameter int                RST_CYCLES = 2,
  parameter logic [ADDR_W-1:0] MMIO_ADDR  = 14'h3FFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wrEn,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
`ifdef VSCPU_MMIO_OUT_EN
  ,
  output logic [7:0]        gpio_out
`endif
);

  localparam int AW1 = ADDR_W + 1;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_V   = AW1'(DEPTH);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     hold_cnt;
  logic [ADDR_W:0]   ld_addr;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_word;
  logic [31:0]       word_nxt;
  logic              acc, word_done, ld_in_range, cpu_in_range;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [MW-1:0]     mem_waddr;
  logic [31:0]       mem_wdata;

  assign acc          = ld_ready && ld_valid;
  assign word_done    = acc && (byte_idx == 2'd3 || ld_last);
  assign ld_in_range  = ld_addr < DEPTH_V;
  assign cpu_in_range = {1'b0, cpu_addr} < DEPTH_V;
  // Unfilled upper bytes are still zero in asm_word, which gives the padding for free.
  assign word_nxt     = asm_word | ({24'b0, ld_data} << {byte_idx, 3'b000});
  assign words_loaded = ld_addr;

  always_comb begin
    state_nxt = state;
    cpu_rst   = 1'b1;
    ld_ready  = 1'b0;
    load_busy = 1'b0;
    case (state)
      S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN: begin
        cpu_rst = 1'b0;
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        if (ld_valid && ld_last) state_nxt = S_HOLD;
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      ld_addr  <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == S_HOLD && state_nxt == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (state == S_RUN && load_start) begin
        ld_addr  <= '0;
        byte_idx <= '0;
        asm_word <= '0;
        load_err <= 1'b0;
      end else if (acc) begin
        if (word_done) begin
          byte_idx <= '0;
          asm_word <= '0;
          // Past the end the stream keeps draining; only the flag records the loss.
          if (ld_in_range) ld_addr <= ld_addr + 1'b1;
          else             load_err <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          asm_word <= word_nxt;
        end
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr[MW-1:0];
    mem_wdata = cpu_wdata;
    if (state == S_RUN) begin
      mem_we = cpu_wrEn && cpu_in_range;
    end else if (word_done && ld_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr[MW-1:0];
      mem_wdata = word_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Non-blocking read alongside the write gives read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (rst)                                 cpu_rdata <= '0;
    else if (state == S_RUN && cpu_in_range) cpu_rdata <= mem[cpu_addr[MW-1:0]];
    else                                     cpu_rdata <= '0;
  end

`ifdef VSCPU_MMIO_OUT_EN
  always_ff @(posedge clk) begin
    if (rst)                                                    gpio_out <= '0;
    else if (state == S_RUN && cpu_wrEn && cpu_addr == MMIO_ADDR) gpio_out <= cpu_wdata[7:0];
  end
`else
  // Without the output register MMIO_ADDR is ordinary memory.
  logic unused_mmio;
  assign unused_mmio = ^MMIO_ADDR;
`endif

endmodule

// File: tb/tb_vscpu_boot_mem.sv
// Directed bench for vscpu_boot_mem: a full-size instance and a DEPTH=4 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_vscpu_boot_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] cpu_addr = '0;
  logic        cpu_wrEn = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;

  logic [31:0] b_rdata, s_rdata;
  logic        b_cpu_rst, s_cpu_rst, b_ready, s_ready, b_busy, s_busy, b_err, s_err;
  logic [14:0] b_words, s_words;
`ifdef VSCPU_MMIO_OUT_EN
  logic [7:0]  b_gpio, s_gpio;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vscpu_boot_mem u_big (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wrEn(cpu_wrEn), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_rdata), .cpu_rst(b_cpu_rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ready), .load_busy(b_busy),
    .load_err(b_err), .words_loaded(b_words)
`ifdef VSCPU_MMIO_OUT_EN
    , .gpio_out(b_gpio)
`endif
  );

  vscpu_boot_mem #(.DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wrEn(cpu_wrEn), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_rdata), .cpu_rst(s_cpu_rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(s_ready), .load_busy(s_busy),
    .load_err(s_err), .words_loaded(s_words)
`ifdef VSCPU_MMIO_OUT_EN
    , .gpio_out(s_gpio)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a);
    cpu_addr = a;
    cpu_wrEn = 1'b0;
    tick();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst cpu_rst", 32'(b_cpu_rst), 32'd1);
    chk("rst rdata", b_rdata, 32'h0);
    chk("rst ready", 32'(b_ready), 32'd0);
    chk("rst busy", 32'(b_busy), 32'd0);
    chk("rst err", 32'(b_err), 32'd0);
    chk("rst words", 32'(b_words), 32'd0);
    rst = 1'b0;
    tick();
    chk("hold cyc1", 32'(b_cpu_rst), 32'd1);
    tick();
    chk("release", 32'(b_cpu_rst), 32'd0);

    // 8-byte load with a valid bubble mid-stream
    start_load();
    chk("load busy", 32'(b_busy), 32'd1);
    chk("load ready", 32'(b_ready), 32'd1);
    chk("load cpu_rst", 32'(b_cpu_rst), 32'd1);
    send(8'h01, 0); send(8'h02, 0);
    ld_data = 8'hFF; tick();
    send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
    chk("ld8 words", 32'(b_words), 32'd2);
    chk("ld8 err", 32'(b_err), 32'd0);
    chk("ld8 busy", 32'(b_busy), 32'd0);
    chk("ld8 +1 cpu_rst", 32'(b_cpu_rst), 32'd1);
    tick();
    chk("ld8 +2 cpu_rst", 32'(b_cpu_rst), 32'd1);
    tick();
    chk("ld8 +3 cpu_rst", 32'(b_cpu_rst), 32'd0);
    rd(14'd0);
    chk("ld8 mem0", b_rdata, 32'h04030201);
    rd(14'd1);
    chk("ld8 mem1", b_rdata, 32'h08070605);
    chk("ld8 small mem1", s_rdata, 32'h08070605);

    // 5-byte load: second word zero-padded
    start_load();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 1);
    chk("ld5 words", 32'(b_words), 32'd2);
    tick(); tick();
    rd(14'd0);
    chk("ld5 mem0", b_rdata, 32'hDDCCBBAA);
    rd(14'd1);
    chk("ld5 mem1 pad", b_rdata, 32'h000000EE);

    // read-before-write on the same address
    cpu_addr = 14'h0010; cpu_wdata = 32'h11111111; cpu_wrEn = 1'b1; tick();
    cpu_wdata = 32'hDEADBEEF; tick();
    chk("rbw old", b_rdata, 32'h11111111);
    rd(14'h0010);
    chk("rbw new", b_rdata, 32'hDEADBEEF);
    chk("oob small rd", s_rdata, 32'h0);

`ifdef VSCPU_MMIO_OUT_EN
    cpu_addr = 14'h3FFF; cpu_wdata = 32'h000001A5; cpu_wrEn = 1'b1; tick();
    cpu_wrEn = 1'b0;
    chk("mmio gpio", 32'(b_gpio), 32'hA5);
    rd(14'h3FFF);
    chk("mmio mem", b_rdata, 32'h000001A5);
`endif

    // 5 full words: the DEPTH=4 instance overflows
    start_load();
    for (int j = 0; j < 20; j++) send(8'(8'h10 + j), j == 19);
    chk("ovf small err", 32'(s_err), 32'd1);
    chk("ovf small words", 32'(s_words), 32'd4);
    chk("ovf big err", 32'(b_err), 32'd0);
    chk("ovf big words", 32'(b_words), 32'd5);
    tick(); tick();
    rd(14'd0);
    chk("ovf small mem0", s_rdata, 32'h13121110);
    rd(14'd3);
    chk("ovf small mem3", s_rdata, 32'h1F1E1D1C);
    rd(14'd4);
    chk("ovf big mem4", b_rdata, 32'h23222120);
    chk("ovf small mem4", s_rdata, 32'h0);
    start_load();
    chk("restart clr err", 32'(s_err), 32'd0);
    chk("restart clr words", 32'(s_words), 32'd0);

    // one full word, then reset mid-load
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    chk("mid words", 32'(b_words), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort cpu_rst", 32'(b_cpu_rst), 32'd1);
    chk("abort busy", 32'(b_busy), 32'd0);
    chk("abort words", 32'(b_words), 32'd0);
`ifdef VSCPU_MMIO_OUT_EN
    chk("abort gpio", 32'(b_gpio), 32'h0);
`endif
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("abort hold", 32'(b_cpu_rst), 32'd1);
    tick();
    chk("abort release", 32'(b_cpu_rst), 32'd0);
    chk("hold ignores start", 32'(b_busy), 32'd0);
    rd(14'd0);
    chk("abort kept mem0", b_rdata, 32'h88776655);

    // loader bytes outside LOAD are ignored
    cpu_addr = 14'd0; ld_valid = 1'b1; ld_data = 8'h99; ld_last = 1'b1; tick();
    chk("run ready", 32'(b_ready), 32'd0);
    chk("run words", 32'(b_words), 32'd0);
    ld_valid = 1'b0; ld_last = 1'b0;
    rd(14'd0);
    chk("run mem0 kept", b_rdata, 32'h88776655);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
